sipo_deframer: RTL and testbench

Serial-in, parallel-out receive stage that sits directly downstream of the parallel-in serial-out shifter. It collects one bit per qualified clock from the shifter's serial output and reassembles WIDTH-bit words. Each completed word is presented on a valid/ready output port. A sticky overrun flag records words lost while the consumer stalls, and a sync input realigns word framing.

---
 rtl/sipo_deframer.sv | 137 +++++++++++++
 tb/tb_sipo_deframer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_deframer.sv
`default_nettype none
// ============================================================================
// Module      : sipo_deframer
// Description : Serial-in, parallel-out receive stage. Collects one bit per
//               qualified clock and reassembles WIDTH-bit words, presented
//               on a valid/ready output slot with a sticky overrun flag.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous, active-low reset
//   serial_in  in   1      serial data bit
//   bit_valid  in   1      serial_in is sampled this edge
//   sync       in   1      bit sampled this cycle (if any) is bit 0 of a word
//   out_ready  in   1      consumer accepts data_out when out_valid=1
//   ovr_clr    in   1      clears overrun (a simultaneous drop wins)
//   data_out   out  WIDTH  last completed word, stable while out_valid=1
//   out_valid  out  1      data_out holds an unaccepted word
//   overrun    out  1      sticky: a completed word was dropped
//   busy       out  1      partial word in progress
// ============================================================================
module sipo_deframer #(
   parameter int WIDTH     = 4,
   parameter int LSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             serial_in,
   input  logic             bit_valid,
   input  logic             sync,
   input  logic             out_ready,
   input  logic             ovr_clr,
   output logic [WIDTH-1:0] data_out,
   output logic             out_valid,
   output logic             overrun,
   output logic             busy
);

   localparam int                CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_t;

   slot_t              slot_q, slot_d;
   logic [WIDTH-1:0]   sh_q, sh_d;
   logic [WIDTH-1:0]   data_q, data_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovr_q, ovr_d;

   logic [WIDTH-1:0]   sh_shift;
   logic [CNT_W-1:0]   cnt_eff;
   logic               word_done;

   // Bit order only changes which end of the shift register is fed.
   generate
      if (LSB_FIRST != 0) begin : g_lsb_first
         assign sh_shift = {serial_in, sh_q[WIDTH-1:1]};
      end else begin : g_msb_first
         assign sh_shift = {sh_q[WIDTH-2:0], serial_in};
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         slot_q <= SLOT_EMPTY;
         sh_q   <= '0;
         data_q <= '0;
         cnt_q  <= '0;
         ovr_q  <= 1'b0;
      end else begin
         slot_q <= slot_d;
         sh_q   <= sh_d;
         data_q <= data_d;
         cnt_q  <= cnt_d;
         ovr_q  <= ovr_d;
      end
   end

   always_comb begin
      slot_d    = slot_q;
      sh_d      = sh_q;
      data_d    = data_q;
      cnt_d     = cnt_q;
      ovr_d     = ovr_q;
      word_done = 1'b0;

      // sync forces the current bit (if any) to be bit 0 of a fresh word.
      cnt_eff = sync ? '0 : cnt_q;

      if (bit_valid) begin
         sh_d = sh_shift;
         if (cnt_eff == LAST_CNT) begin
            word_done = 1'b1;
            cnt_d     = '0;
         end else begin
            cnt_d = cnt_eff + CNT_W'(1);
         end
      end else if (sync) begin
         cnt_d = '0;
      end

      if (ovr_clr) begin
         ovr_d = 1'b0;
      end

      case (slot_q)
         SLOT_EMPTY: begin
            if (word_done) begin
               data_d = sh_d;
               slot_d = SLOT_FULL;
            end
         end
         SLOT_FULL: begin
            if (word_done && out_ready) begin
               // Accept and reload in the same cycle: no gap, no overrun.
               data_d = sh_d;
            end else if (word_done) begin
               // Consumer stalled: drop the new word; beats ovr_clr.
               ovr_d = 1'b1;
            end else if (out_ready) begin
               slot_d = SLOT_EMPTY;
            end
         end
         default: slot_d = SLOT_EMPTY;
      endcase
   end

   assign data_out  = data_q;
   assign out_valid = (slot_q == SLOT_FULL);
   assign overrun   = ovr_q;
   assign busy      = (cnt_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_sipo_deframer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sipo_deframer
// Description : Self-checking bench for sipo_deframer. Drives an LSB-first
//               and an MSB-first instance (WIDTH=4) with the same directed
//               bit stream and compares both against a bit-list model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sipo_deframer;

   localparam int W = 4;

   logic         clk;
   logic         reset;
   logic         serial_in;
   logic         bit_valid;
   logic         sync;
   logic         out_ready;
   logic         ovr_clr;

   logic [W-1:0] data_l, data_m;
   logic         valid_l, valid_m;
   logic         ovr_l, ovr_m;
   logic         busy_l, busy_m;

   int checks   = 0;
   int failures = 0;

   sipo_deframer #(.WIDTH(W), .LSB_FIRST(1)) u_dut_lsb (
      .clk       (clk),
      .reset     (reset),
      .serial_in (serial_in),
      .bit_valid (bit_valid),
      .sync      (sync),
      .out_ready (out_ready),
      .ovr_clr   (ovr_clr),
      .data_out  (data_l),
      .out_valid (valid_l),
      .overrun   (ovr_l),
      .busy      (busy_l)
   );

   sipo_deframer #(.WIDTH(W), .LSB_FIRST(0)) u_dut_msb (
      .clk       (clk),
      .reset     (reset),
      .serial_in (serial_in),
      .bit_valid (bit_valid),
      .sync      (sync),
      .out_ready (out_ready),
      .ovr_clr   (ovr_clr),
      .data_out  (data_m),
      .out_valid (valid_m),
      .overrun   (ovr_m),
      .busy      (busy_m)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   // Received bits are kept as a list in arrival order; a word is formed
   // only when W bits have been collected.
   int           m_bits [W];
   int           m_n;
   logic [W-1:0] m_dl, m_dm;
   logic         m_valid;
   logic         m_ovr;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_n     = 0;
         m_dl    = '0;
         m_dm    = '0;
         m_valid = 1'b0;
         m_ovr   = 1'b0;
      end else begin
         bit done;
         done = 1'b0;
         if (sync) m_n = 0;
         if (bit_valid) begin
            m_bits[m_n] = int'(serial_in);
            m_n = m_n + 1;
            if (m_n == W) begin
               done = 1'b1;
               m_n  = 0;
            end
         end
         if (ovr_clr) m_ovr = 1'b0;
         if (done) begin
            if (!m_valid || out_ready) begin
               for (int i = 0; i < W; i++) begin
                  m_dl[i]       = m_bits[i][0];
                  m_dm[W-1-i]   = m_bits[i][0];
               end
               m_valid = 1'b1;
            end else begin
               m_ovr = 1'b1;
            end
         end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
         end
      end
   end

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      cmp("valid_lsb", {31'd0, valid_l}, {31'd0, m_valid});
      cmp("valid_msb", {31'd0, valid_m}, {31'd0, m_valid});
      cmp("ovr_lsb",   {31'd0, ovr_l},   {31'd0, m_ovr});
      cmp("ovr_msb",   {31'd0, ovr_m},   {31'd0, m_ovr});
      cmp("busy_lsb",  {31'd0, busy_l},  {31'd0, (m_n != 0)});
      cmp("busy_msb",  {31'd0, busy_m},  {31'd0, (m_n != 0)});
      cmp("data_lsb",  {28'd0, data_l},  {28'd0, m_dl});
      cmp("data_msb",  {28'd0, data_m},  {28'd0, m_dm});
   end

   // ---------------- stimulus ----------------
   task automatic step(input logic bv, input logic si, input logic sy, input logic clr);
      bit_valid = bv;
      serial_in = si;
      sync      = sy;
      ovr_clr   = clr;
      @(posedge clk);
      #1;
      bit_valid = 1'b0;
      serial_in = 1'b0;
      sync      = 1'b0;
      ovr_clr   = 1'b0;
   endtask

   // Sends four bits in arrival order, sync on the first.
   task automatic send_word(input logic [3:0] bits_in_order);
      for (int i = 0; i < 4; i++) step(1'b1, bits_in_order[3-i], (i == 0), 1'b0);
   endtask

   initial begin
      reset     = 1'b0;
      serial_in = 1'b0;
      bit_valid = 1'b0;
      sync      = 1'b0;
      out_ready = 1'b1;
      ovr_clr   = 1'b0;
      #12;
      cmp("reset_valid", {31'd0, valid_l}, 32'd0);
      cmp("reset_data",  {28'd0, data_l},  32'd0);
      cmp("reset_busy",  {31'd0, busy_l},  32'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      // T1: bits 0,1,1,0 with busy tracking
      step(1'b1, 1'b0, 1'b1, 1'b0); cmp("t1_busy1", {31'd0, busy_l}, 32'd1);
      step(1'b1, 1'b1, 1'b0, 1'b0); cmp("t1_busy2", {31'd0, busy_l}, 32'd1);
      step(1'b1, 1'b1, 1'b0, 1'b0); cmp("t1_busy3", {31'd0, busy_l}, 32'd1);
      cmp("t1_valid_pre", {31'd0, valid_l}, 32'd0);
      step(1'b1, 1'b0, 1'b0, 1'b0); cmp("t1_busy4", {31'd0, busy_l}, 32'd0);
      cmp("t1_valid", {31'd0, valid_l}, 32'd1);
      cmp("t1_data_lsb", {28'd0, data_l}, 32'h6);
      cmp("t1_data_msb", {28'd0, data_m}, 32'h6);
      cmp("t1_model", {28'd0, m_dl}, 32'h6);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      cmp("t1_drained", {31'd0, valid_l}, 32'd0);

      // T2: bit order 1,0,0,1 then 1,1,0,0 (distinguishes bit order)
      send_word(4'b1001);
      cmp("t2_data_msb9", {28'd0, data_m}, 32'h9);
      cmp("t2_data_lsb9", {28'd0, data_l}, 32'h9);
      send_word(4'b1100);
      cmp("t2_data_lsb3", {28'd0, data_l}, 32'h3);
      cmp("t2_data_msbC", {28'd0, data_m}, 32'hC);
      cmp("t2_model_msb", {28'd0, m_dm}, 32'hC);
      step(1'b0, 1'b0, 1'b0, 1'b0);

      // T3: stalled consumer, word A then 5 -> drop and overrun
      out_ready = 1'b0;
      send_word(4'b0101);             // A LSB-first
      cmp("t3_dataA", {28'd0, data_l}, 32'hA);
      send_word(4'b1010);             // 5 LSB-first
      cmp("t3_hold", {28'd0, data_l}, 32'hA);
      cmp("t3_valid", {31'd0, valid_l}, 32'd1);
      cmp("t3_ovr", {31'd0, ovr_l}, 32'd1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      cmp("t3_ovr_clr", {31'd0, ovr_l}, 32'd0);
      // drop coincident with ovr_clr: drop wins
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, (i == 0), 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      cmp("t3_drop_wins", {31'd0, ovr_l}, 32'd1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      out_ready = 1'b1;
      step(1'b0, 1'b0, 1'b0, 1'b0);
      cmp("t3_drained", {31'd0, valid_l}, 32'd0);

      // T4: 3 then C, ready only on completion cycle of second word
      out_ready = 1'b0;
      send_word(4'b1100);             // 3 LSB-first
      step(1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      out_ready = 1'b1;
      step(1'b1, 1'b1, 1'b0, 1'b0);   // C LSB-first completes
      out_ready = 1'b0;
      cmp("t4_dataC", {28'd0, data_l}, 32'hC);
      cmp("t4_valid", {31'd0, valid_l}, 32'd1);
      cmp("t4_ovr", {31'd0, ovr_l}, 32'd0);
      out_ready = 1'b1;
      step(1'b0, 1'b0, 1'b0, 1'b0);

      // T5: partial word discarded by sync
      step(1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      cmp("t5_no_pulse", {31'd0, valid_l}, 32'd0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      cmp("t5_data9", {28'd0, data_l}, 32'h9);
      cmp("t5_valid", {31'd0, valid_l}, 32'd1);
      step(1'b0, 1'b0, 1'b0, 1'b0);

      // T6: async reset mid-word with out_valid and overrun set
      out_ready = 1'b0;
      send_word(4'b1111);
      send_word(4'b0000);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      cmp("t6_pre_valid", {31'd0, valid_l}, 32'd1);
      cmp("t6_pre_ovr", {31'd0, ovr_l}, 32'd1);
      #2 reset = 1'b0;
      #1;
      cmp("t6_rst_valid", {31'd0, valid_l}, 32'd0);
      cmp("t6_rst_data",  {28'd0, data_l},  32'd0);
      cmp("t6_rst_ovr",   {31'd0, ovr_l},   32'd0);
      cmp("t6_rst_busy",  {31'd0, busy_l},  32'd0);
      reset = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
      cmp("t6_dataF", {28'd0, data_l}, 32'hF);
      cmp("t6_valid", {31'd0, valid_l}, 32'd1);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
